nand_prog_sequencer: RTL and testbench

Upstream command sequencer for `mem_command`: on a single start pulse it runs a complete SPI-NAND page program. The sequence is WRITE_ENABLE, PROG_LOAD1 (cache data from the save FIFO), PROG_EXEC, then GET_FEATURE polling of status register 0xC0 until the operation-in-progress bit clears. It replaces ad-hoc sequencing in `top` and reports pass/fail/timeout plus the last status byte. It never touches FIFO data; the save FIFO must be filled before start.

---
 rtl/nand_prog_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_nand_prog_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_prog_sequencer.sv
// SPI-NAND page-program sequencer driving mem_command: WRITE_ENABLE, PROG_LOAD1, PROG_EXEC,
// then GET_FEATURE polling until OIP clears. o_Command carries the SPI-NAND opcode byte.
module nand_prog_sequencer #(
   parameter int         MAX_POLLS   = 4096,
   parameter int         POLL_GAP    = 16,
   parameter logic [7:0] STATUS_ADDR = 8'hC0
) (
   input  logic        i_Clk,
   input  logic        i_Rst_L,
   input  logic        i_Start,
   input  logic [12:0] i_Col_Addr,
   input  logic [23:0] i_Row_Addr,
   output logic        o_Busy,
   output logic        o_Done,
   output logic        o_Prog_Fail,
   output logic        o_Timeout,
   output logic [7:0]  o_Last_Status,
   output logic [7:0]  o_Command,
   output logic        o_CM_DV,
   output logic [23:0] o_Addr_Data,
   input  logic        i_CM_Ready,
   input  logic [7:0]  i_RX_Feature_Byte,
   input  logic        i_RX_Feature_DV
);
   localparam logic [7:0] CMD_WRITE_ENABLE = 8'h06;
   localparam logic [7:0] CMD_PROG_LOAD1   = 8'h02;
   localparam logic [7:0] CMD_PROG_EXEC    = 8'h10;
   localparam logic [7:0] CMD_GET_FEATURE  = 8'h0F;

   localparam int             PCW      = $clog2(MAX_POLLS + 1);
   localparam int             GCW      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [PCW-1:0] POLL_MAX = PCW'(MAX_POLLS);
   localparam logic [GCW-1:0] GAP_LAST = (POLL_GAP > 1) ? GCW'(POLL_GAP - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE, S_WREN, S_LOAD, S_EXEC, S_GAP, S_POLL, S_EVAL, S_DONE
   } state_t;

   typedef enum logic [1:0] {
      ST_ISSUE, ST_ACK, ST_CMPL
   } step_t;

   state_t         state, state_n;
   step_t          step, step_n;
   logic [GCW-1:0] gap_cnt, gap_n;
   logic [PCW-1:0] poll_cnt, poll_n;
   logic           captured, cap_n;
   logic [12:0]    col_q, col_n;
   logic [23:0]    row_q, row_n;
   logic           busy_n, done_n, fail_n, tmo_n, dv_n;
   logic [7:0]     stat_n, cmd_n;
   logic [23:0]    addr_n;

   // Poll count holds at MAX_POLLS instead of wrapping.
   function automatic logic [PCW-1:0] sat_inc(input logic [PCW-1:0] v);
      return (v == POLL_MAX) ? v : v + PCW'(1);
   endfunction

   function automatic logic [7:0] cmd_of(input state_t s);
      case (s)
         S_LOAD:  return CMD_PROG_LOAD1;
         S_EXEC:  return CMD_PROG_EXEC;
         S_POLL:  return CMD_GET_FEATURE;
         default: return CMD_WRITE_ENABLE;
      endcase
   endfunction

   function automatic logic [23:0] addr_of(input state_t s, input logic [12:0] col,
                                           input logic [23:0] row);
      case (s)
         S_LOAD:  return {11'd0, col};
         S_EXEC:  return row;
         S_POLL:  return {8'd0, STATUS_ADDR, 8'd0};
         default: return 24'd0;
      endcase
   endfunction

   function automatic state_t after_cmd(input state_t s);
      case (s)
         S_WREN:  return S_LOAD;
         S_LOAD:  return S_EXEC;
         S_EXEC:  return S_GAP;
         default: return S_EVAL;
      endcase
   endfunction

   always_comb begin
      state_n = state;
      step_n  = step;
      gap_n   = gap_cnt;
      poll_n  = poll_cnt;
      cap_n   = captured;
      col_n   = col_q;
      row_n   = row_q;
      busy_n  = o_Busy;
      done_n  = 1'b0;
      fail_n  = o_Prog_Fail;
      tmo_n   = o_Timeout;
      stat_n  = o_Last_Status;
      cmd_n   = o_Command;
      addr_n  = o_Addr_Data;
      dv_n    = 1'b0;

      case (state)
         S_IDLE: begin
            if (i_Start) begin
               col_n   = i_Col_Addr;
               row_n   = i_Row_Addr;
               fail_n  = 1'b0;
               tmo_n   = 1'b0;
               poll_n  = '0;
               stat_n  = 8'h00;
               cap_n   = 1'b0;
               busy_n  = 1'b1;
               step_n  = ST_ISSUE;
               state_n = S_WREN;
            end
         end

         S_WREN, S_LOAD, S_EXEC, S_POLL: begin
            case (step)
               ST_ISSUE: begin
                  if (i_CM_Ready) begin
                     dv_n   = 1'b1;
                     cmd_n  = cmd_of(state);
                     addr_n = addr_of(state, col_q, row_q);
                     step_n = ST_ACK;
                     if (state == S_POLL) begin
                        poll_n = sat_inc(poll_cnt);
                        cap_n  = 1'b0;
                     end
                  end
               end
               ST_ACK: begin
                  if (!i_CM_Ready) step_n = ST_CMPL;
               end
               default: begin
                  if (i_CM_Ready) begin
                     step_n  = ST_ISSUE;
                     gap_n   = '0;
                     state_n = after_cmd(state);
                  end
               end
            endcase
            // The feature byte may land together with the ready rise; it is still taken here.
            if (state == S_POLL && step != ST_ISSUE && i_RX_Feature_DV) begin
               stat_n = i_RX_Feature_Byte;
               cap_n  = 1'b1;
            end
         end

         S_GAP: begin
            if (gap_cnt >= GAP_LAST) begin
               step_n  = ST_ISSUE;
               state_n = S_POLL;
            end else begin
               gap_n = gap_cnt + GCW'(1);
            end
         end

         S_EVAL: begin
            if (captured && !o_Last_Status[0]) begin
               fail_n  = o_Last_Status[3];
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = S_DONE;
            end else if (poll_cnt < POLL_MAX) begin
               gap_n   = '0;
               state_n = S_GAP;
            end else begin
               tmo_n   = 1'b1;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = S_DONE;
            end
         end

         S_DONE: state_n = S_IDLE;

         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state         <= S_IDLE;
         step          <= ST_ISSUE;
         gap_cnt       <= '0;
         poll_cnt      <= '0;
         captured      <= 1'b0;
         col_q         <= '0;
         row_q         <= '0;
         o_Busy        <= 1'b0;
         o_Done        <= 1'b0;
         o_Prog_Fail   <= 1'b0;
         o_Timeout     <= 1'b0;
         o_Last_Status <= 8'h00;
         o_Command     <= CMD_WRITE_ENABLE;
         o_Addr_Data   <= 24'd0;
         o_CM_DV       <= 1'b0;
      end else begin
         state         <= state_n;
         step          <= step_n;
         gap_cnt       <= gap_n;
         poll_cnt      <= poll_n;
         captured      <= cap_n;
         col_q         <= col_n;
         row_q         <= row_n;
         o_Busy        <= busy_n;
         o_Done        <= done_n;
         o_Prog_Fail   <= fail_n;
         o_Timeout     <= tmo_n;
         o_Last_Status <= stat_n;
         o_Command     <= cmd_n;
         o_Addr_Data   <= addr_n;
         o_CM_DV       <= dv_n;
      end
   end

endmodule

// File: tb/tb_nand_prog_sequencer.sv
// Bench for nand_prog_sequencer: behavioural mem_command model plus a reference of the
// expected command list and completion flags for each program run.
module tb_nand_prog_sequencer;
   localparam int         MAXP = 4;
   localparam int         GAP  = 16;
   localparam int         HOLD = 20;
   localparam logic [7:0] WREN = 8'h06;
   localparam logic [7:0] LOAD = 8'h02;
   localparam logic [7:0] EXEC = 8'h10;
   localparam logic [7:0] GETF = 8'h0F;

   logic        i_Clk;
   logic        i_Rst_L;
   logic        i_Start;
   logic [12:0] i_Col_Addr;
   logic [23:0] i_Row_Addr;
   logic        o_Busy, o_Done, o_Prog_Fail, o_Timeout, o_CM_DV;
   logic [7:0]  o_Last_Status, o_Command;
   logic [23:0] o_Addr_Data;
   logic        i_CM_Ready;
   logic [7:0]  i_RX_Feature_Byte;
   logic        i_RX_Feature_DV;

   nand_prog_sequencer #(.MAX_POLLS(MAXP), .POLL_GAP(GAP), .STATUS_ADDR(8'hC0)) dut (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start),
      .i_Col_Addr(i_Col_Addr), .i_Row_Addr(i_Row_Addr),
      .o_Busy(o_Busy), .o_Done(o_Done), .o_Prog_Fail(o_Prog_Fail), .o_Timeout(o_Timeout),
      .o_Last_Status(o_Last_Status), .o_Command(o_Command), .o_CM_DV(o_CM_DV),
      .o_Addr_Data(o_Addr_Data), .i_CM_Ready(i_CM_Ready),
      .i_RX_Feature_Byte(i_RX_Feature_Byte), .i_RX_Feature_DV(i_RX_Feature_DV)
   );

   initial begin
      i_Clk = 1'b0;
      forever #5 i_Clk = ~i_Clk;
   end

   int          tests_run, tests_failed;
   int          busy_left, cmd_busy, gap_ctr, poll_n, done_cnt;
   bit          hold_mode, pre_hold, gap_meas, last_feat, cur_feat, cur_skip, early;
   logic        prev_dv, prev_busy, d_fail, d_tmo;
   logic [7:0]  cur_cmd, cur_byte, d_stat, b;
   logic [23:0] cur_addr;
   logic [7:0]  cmd_q[$];
   logic [23:0] addr_q[$];
   logic [7:0]  stat_seq[$];
   bit          skip_seq[$];
   int          ns;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge i_Clk);
      #1;
   endtask

   function automatic logic [7:0] stat_at(input int i);
      if (i < stat_seq.size()) return stat_seq[i];
      return stat_seq[stat_seq.size() - 1];
   endfunction

   function automatic bit skip_at(input int i);
      if (i < skip_seq.size()) return skip_seq[i];
      return 1'b0;
   endfunction

   function automatic logic [7:0] exp_cmd(input int i);
      if (i == 0) return WREN;
      if (i == 1) return LOAD;
      if (i == 2) return EXEC;
      return GETF;
   endfunction

   function automatic logic [23:0] exp_addr(input int i, input logic [12:0] c, input logic [23:0] r);
      if (i == 1) return {11'd0, c};
      if (i == 2) return r;
      if (i >= 3) return 24'h00C000;
      return 24'd0;
   endfunction

   task automatic run_prog(input logic [12:0] col, input logic [23:0] row, input int busy,
                           input bit hold, input bit extra, input string nm);
      int         exp_polls, d0, n;
      bit         exp_fail, exp_tmo;
      logic [7:0] exp_last, sb;
      exp_last  = 8'h00;
      exp_fail  = 1'b0;
      exp_tmo   = 1'b0;
      exp_polls = 0;
      for (int p = 0; p < MAXP; p++) begin
         exp_polls = p + 1;
         sb = stat_at(p);
         if (!skip_at(p)) begin
            exp_last = sb;
            if (!sb[0]) begin
               exp_fail = sb[3];
               break;
            end
         end
         if (p == MAXP - 1) exp_tmo = 1'b1;
      end

      cmd_q.delete();
      addr_q.delete();
      cmd_busy   = busy;
      hold_mode  = hold;
      pre_hold   = hold;
      d0         = done_cnt;
      i_Col_Addr = col;
      i_Row_Addr = row;
      i_Start    = 1'b1;
      tick();
      i_Start = 1'b0;
      chk({nm, "_busy_rise"}, 32'(o_Busy), 32'd1);
      if (extra) begin
         repeat (10) tick();
         i_Start = 1'b1;
         tick();
         i_Start = 1'b0;
      end
      n = 0;
      while (done_cnt == d0 && n < 4000) begin
         tick();
         n++;
      end
      chk({nm, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
      if (extra) begin
         i_Start = 1'b1;
         tick();
         i_Start = 1'b0;
      end
      repeat (30) tick();
      chk({nm, "_done_count"}, 32'(done_cnt - d0), 32'd1);
      chk({nm, "_fail"}, 32'(d_fail), 32'(exp_fail));
      chk({nm, "_timeout"}, 32'(d_tmo), 32'(exp_tmo));
      chk({nm, "_last_status"}, 32'(d_stat), 32'(exp_last));
      chk({nm, "_fail_held"}, 32'(o_Prog_Fail), 32'(exp_fail));
      chk({nm, "_tmo_held"}, 32'(o_Timeout), 32'(exp_tmo));
      chk({nm, "_idle"}, 32'(o_Busy), 32'd0);
      chk({nm, "_ncmds"}, 32'(cmd_q.size()), 32'(3 + exp_polls));
      for (int i = 0; i < cmd_q.size() && i < 3 + exp_polls; i++) begin
         chk({nm, "_cmd"}, 32'(cmd_q[i]), 32'(exp_cmd(i)));
         chk({nm, "_addr"}, 32'(addr_q[i]), 32'(exp_addr(i, col, row)));
      end
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      busy_left = 0; cmd_busy = 5; gap_ctr = 0; poll_n = 0; done_cnt = 0;
      hold_mode = 0; pre_hold = 0; gap_meas = 0; last_feat = 0; cur_feat = 0;
      cur_skip = 0; early = 0; prev_dv = 0; prev_busy = 0;
      d_fail = 0; d_tmo = 0; d_stat = 0; cur_cmd = 0; cur_byte = 0; cur_addr = 0;
      i_Rst_L = 1'b0; i_Start = 1'b0; i_Col_Addr = '0; i_Row_Addr = '0;
      i_CM_Ready = 1'b1; i_RX_Feature_Byte = 8'h00; i_RX_Feature_DV = 1'b0;

      fork
         forever begin
            @(negedge i_Clk);
            i_RX_Feature_DV = 1'b0;
            if (!i_Rst_L) begin
               busy_left  = 0;
               i_CM_Ready = 1'b1;
               gap_meas   = 0;
               prev_dv    = 1'b0;
               prev_busy  = 1'b0;
            end else begin
               if (gap_meas) gap_ctr++;
               if (o_Done) begin
                  done_cnt++;
                  d_fail = o_Prog_Fail;
                  d_tmo  = o_Timeout;
                  d_stat = o_Last_Status;
                  chk("busy_fall", 32'({prev_busy, o_Busy}), 32'd2);
               end
               if (pre_hold && !o_CM_DV && busy_left == 0) begin
                  pre_hold   = 0;
                  i_CM_Ready = 1'b0;
                  busy_left  = HOLD;
                  cur_cmd    = o_Command;
                  cur_addr   = o_Addr_Data;
                  cur_feat   = 0;
               end else if (o_CM_DV) begin
                  chk("dv_ready", 32'(i_CM_Ready), 32'd1);
                  chk("dv_single", 32'(prev_dv), 32'd0);
                  if (o_Command == GETF && last_feat && gap_meas)
                     chk("poll_gap", 32'(gap_ctr), 32'(GAP + 3));
                  gap_meas = 0;
                  if (o_Command == WREN) poll_n = 0;
                  cmd_q.push_back(o_Command);
                  addr_q.push_back(o_Addr_Data);
                  cur_cmd   = o_Command;
                  cur_addr  = o_Addr_Data;
                  cur_feat  = (o_Command == GETF);
                  last_feat = cur_feat;
                  if (cur_feat) begin
                     cur_byte = stat_at(poll_n);
                     cur_skip = skip_at(poll_n);
                     poll_n++;
                  end
                  early      = ($urandom_range(0, 1) == 1);
                  i_CM_Ready = 1'b0;
                  busy_left  = cmd_busy + (hold_mode ? HOLD : 0);
               end else if (busy_left > 0) begin
                  chk("cmd_stable", 32'(o_Command), 32'(cur_cmd));
                  chk("addr_stable", 32'(o_Addr_Data), 32'(cur_addr));
                  busy_left--;
                  if (cur_feat && !cur_skip && early && busy_left == 1) begin
                     i_RX_Feature_DV   = 1'b1;
                     i_RX_Feature_Byte = cur_byte;
                     cur_skip          = 1;
                  end
                  if (busy_left == 0) begin
                     i_CM_Ready = 1'b1;
                     if (cur_feat && !cur_skip) begin
                        i_RX_Feature_DV   = 1'b1;
                        i_RX_Feature_Byte = cur_byte;
                     end
                     if (cur_feat) begin
                        gap_meas = 1;
                        gap_ctr  = 0;
                     end
                  end
               end
               prev_dv   = o_CM_DV;
               prev_busy = o_Busy;
            end
         end
      join_none

      repeat (3) tick();
      chk("rst_busy", 32'(o_Busy), 32'd0);
      chk("rst_done", 32'(o_Done), 32'd0);
      chk("rst_fail", 32'(o_Prog_Fail), 32'd0);
      chk("rst_tmo", 32'(o_Timeout), 32'd0);
      chk("rst_dv", 32'(o_CM_DV), 32'd0);
      chk("rst_addr", 32'(o_Addr_Data), 32'd0);
      chk("rst_status", 32'(o_Last_Status), 32'd0);
      chk("rst_cmd", 32'(o_Command), 32'(WREN));
      i_Rst_L = 1'b1;
      tick();

      stat_seq = '{8'h01, 8'h01, 8'h00}; skip_seq.delete();
      run_prog(13'h034, 24'h000100, 5, 0, 0, "nominal");

      stat_seq = '{8'h01, 8'h08}; skip_seq.delete();
      run_prog(13'h1A5, 24'h012345, 5, 0, 0, "progfail");

      stat_seq = '{8'h01}; skip_seq.delete();
      run_prog(13'h0FF, 24'hABCDEF, 4, 0, 0, "timeout");

      stat_seq = '{8'h01, 8'h00}; skip_seq.delete();
      run_prog(13'h1FFF, 24'hFFFFFF, 5, 1, 1, "handshake");

      stat_seq = '{8'h01, 8'h01, 8'h00}; skip_seq = '{1'b0, 1'b1, 1'b0};
      run_prog(13'h002, 24'h000200, 3, 0, 0, "missing");

      stat_seq = '{8'h01}; skip_seq.delete();
      cmd_busy = 5; hold_mode = 0; pre_hold = 0;
      ns = done_cnt;
      i_Col_Addr = 13'h010; i_Row_Addr = 24'h000010; i_Start = 1'b1;
      tick();
      i_Start = 1'b0;
      for (int n = 0; n < 2000 && poll_n == 0; n++) tick();
      chk("rst_poll_reached", 32'(poll_n != 0), 32'd1);
      i_Rst_L = 1'b0;
      #1;
      chk("rstp_busy", 32'(o_Busy), 32'd0);
      chk("rstp_done", 32'(o_Done), 32'd0);
      chk("rstp_dv", 32'(o_CM_DV), 32'd0);
      chk("rstp_addr", 32'(o_Addr_Data), 32'd0);
      chk("rstp_cmd", 32'(o_Command), 32'(WREN));
      chk("rstp_status", 32'(o_Last_Status), 32'd0);
      chk("rstp_fail_tmo", 32'({o_Prog_Fail, o_Timeout}), 32'd0);
      repeat (3) tick();
      i_Rst_L = 1'b1;
      repeat (5) tick();
      chk("rstp_no_done", 32'(done_cnt - ns), 32'd0);
      stat_seq = '{8'h01, 8'h01, 8'h00}; skip_seq.delete();
      run_prog(13'h034, 24'h000100, 5, 0, 0, "after_rst");

      for (int k = 0; k < 8; k++) begin
         ns = $urandom_range(1, 5);
         stat_seq.delete();
         skip_seq.delete();
         for (int j = 0; j < ns; j++) begin
            b = 8'($urandom);
            if (j < ns - 1) b[0] = 1'b1;
            else b[0] = ($urandom_range(0, 3) == 0);
            stat_seq.push_back(b);
            skip_seq.push_back($urandom_range(0, 4) == 0);
         end
         run_prog(13'($urandom), 24'($urandom), $urandom_range(2, 6),
                  $urandom_range(0, 3) == 0, 1'b0, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
